ccx_mem_sram: RTL

- Downstream consumer of the core complex interconnect's RAM port.
- Terminates the core memory bus request/response protocol onto a single-port synchronous SRAM macro with 1-cycle read latency.
- Handles byte strobes, address range checking and response backpressure, with up to 2 outstanding transactions.
- Sits between the interconnect RAM arbiter output and the on-chip RAM macro.

---
 rtl/ccx_mem_pkg.sv | 29 ++
 rtl/ccx_mem_rsp_fifo.sv | 46 ++++
 rtl/ccx_mem_sram.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ccx_mem_pkg.sv
// Shared types, constants and helpers for the interconnect-to-SRAM bridge.
// Response payload is the unit buffered between the SRAM and the bus.
package ccx_mem_pkg;

  localparam int CCX_MEM_AW      = 39;
  localparam int CCX_MEM_DW      = 64;
  localparam int CCX_MEM_SW      = CCX_MEM_DW / 8;
  localparam int CCX_MEM_DEPTH_W = 13;

  localparam logic [CCX_MEM_AW-1:0] CCX_MEM_BASE = 39'h00010000;
  localparam logic [CCX_MEM_AW-1:0] CCX_MEM_SIZE = 39'h0000FFFF;

  localparam int CCX_MEM_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic                  error;
    logic [CCX_MEM_DW-1:0] rdata;
  } ccx_mem_rsp_t;

  // The lower-bound check comes first so the subtraction never wraps into range.
  function automatic logic ccx_mem_in_range(input logic [CCX_MEM_AW-1:0] addr,
                                            input logic [CCX_MEM_AW-1:0] base,
                                            input logic [CCX_MEM_AW-1:0] size);
    logic [CCX_MEM_AW-1:0] offset;
    offset = addr - base;
    return (addr >= base) && (offset <= size);
  endfunction

endpackage

// File: rtl/ccx_mem_rsp_fifo.sv
// Two-entry response FIFO holding responses the bus has not yet accepted.
// Push and pop may occur in the same cycle.
module ccx_mem_rsp_fifo
  import ccx_mem_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         push,
  input  ccx_mem_rsp_t push_data,
  input  logic         pop,
  output ccx_mem_rsp_t head,
  output logic         full,
  output logic         empty
);

  ccx_mem_rsp_t entries [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Payload storage needs no reset: it is only visible through a non-empty FIFO.
  always_ff @(posedge g_clk) begin
    if (push_ok) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ccx_mem_sram.sv
// Bridges the core memory request/response bus onto a single-port SRAM with
// 1-cycle read latency, with range checking and up to two outstanding responses.
module ccx_mem_sram
  import ccx_mem_pkg::*;
#(
  parameter int                AW      = CCX_MEM_AW,
  parameter int                DW      = CCX_MEM_DW,
  parameter int                SW      = DW / 8,
  parameter int                DEPTH_W = CCX_MEM_DEPTH_W,
  parameter logic [AW-1:0]     BASE    = CCX_MEM_BASE,
  parameter logic [AW-1:0]     SIZE    = CCX_MEM_SIZE
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               mem_req,
  output logic               mem_gnt,
  input  logic               mem_wen,
  input  logic [SW-1:0]      mem_strb,
  input  logic [DW-1:0]      mem_wdata,
  input  logic [AW-1:0]      mem_addr,
  output logic               mem_recv,
  input  logic               mem_ack,
  output logic               mem_error,
  output logic [DW-1:0]      mem_rdata,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [SW-1:0]      sram_strb,
  output logic [DEPTH_W-1:0] sram_addr,
  output logic [DW-1:0]      sram_wdata,
  input  logic [DW-1:0]      sram_rdata
);

  localparam int BW = $clog2(SW);

  logic [AW-1:0] offset;
  logic          in_range;
  logic          accept;
  logic          pop;
  logic [1:0]    outstanding;

  logic          pend_valid;
  logic          pend_read;
  logic          pend_error;
  ccx_mem_rsp_t  pend_rsp;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  ccx_mem_rsp_t  fifo_head;
  ccx_mem_rsp_t  rsp_out;

  assign offset   = mem_addr - BASE;
  assign in_range = ccx_mem_in_range(mem_addr, BASE, SIZE);

  // Grant is a pure function of state so the bus never sees a req->gnt loop.
  assign mem_gnt = g_resetn && (outstanding < 2'(CCX_MEM_MAX_OUTSTANDING));
  assign accept  = mem_req && mem_gnt;

  assign sram_cen   = accept && in_range;
  assign sram_wen   = mem_wen;
  assign sram_strb  = mem_strb;
  assign sram_addr  = offset[DEPTH_W+BW-1:BW];
  assign sram_wdata = mem_wdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
      pend_error <= 1'b0;
    end else begin
      pend_valid <= accept;
      pend_read  <= !mem_wen;
      pend_error <= !in_range;
    end
  end

  // SRAM read data is only meaningful in the cycle right after the access.
  assign pend_rsp.error = pend_valid && pend_error;
  assign pend_rsp.rdata = (pend_valid && pend_read && !pend_error) ? sram_rdata : '0;

  assign mem_recv  = !fifo_empty || pend_valid;
  assign pop       = mem_recv && mem_ack;
  assign fifo_pop  = pop && !fifo_empty;
  assign fifo_push = pend_valid && !(pop && fifo_empty);

  ccx_mem_rsp_fifo u_rsp_fifo (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .push      (fifo_push),
    .push_data (pend_rsp),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rsp_out = pend_rsp;
    if (!fifo_empty) rsp_out = fifo_head;
  end

  assign mem_error = rsp_out.error;
  assign mem_rdata = rsp_out.rdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      outstanding <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO occupancy is bounded by the grant logic, so full is never consulted.
  logic unused_ok;
  assign unused_ok = ^{offset[AW-1:DEPTH_W+BW], offset[BW-1:0], fifo_full};

endmodule
